// File: rtl/conv_pkg.sv
// Shared constants for the convolution output framer: pixel width, tag placement
// and FIFO entry sizing.
package conv_pkg;

  localparam int PIX_W = 8;

  // Tag bit offsets above the packed pixel field inside a FIFO entry {sof, eol, eof, data}
  localparam int SOF_OFS = 2;
  localparam int EOL_OFS = 1;
  localparam int EOF_OFS = 0;

  function automatic int entry_w(input int p);
    return p * PIX_W + 3;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count, synchronous flush
// and asynchronous active-low reset.
module sync_fifo_fwft #(
  parameter int DW    = 35,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (cnt_q == (AW + 1)'(DEPTH));
  assign empty     = (cnt_q == (AW + 1)'(0));
  assign level     = cnt_q;
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok_s) wr_q <= wr_q + AW'(1);
      if (pop_ok_s)  rd_q <= rd_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s && !clear) mem_q[wr_q] <= din;
  end

  // Head entry is forced to zero while empty so outputs show clean reset values.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem_q[rd_q];
    end else begin
      dout = '0;
    end
  end

endmodule

// File: rtl/conv_out_framer.sv
// Packs per-lane convolution results into tagged P-pixel words, buffers them in a
// FWFT FIFO and streams them out, dropping words (sticky overflow) under backpressure.
module conv_out_framer
  import conv_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int P      = 4,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [P-1:0]           in_valid_vec,
  input  logic [P*PIX_W-1:0]     in_pix_vec,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [P*PIX_W-1:0]     m_data,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int DDW  = P * PIX_W;
  localparam int EW   = entry_w(P);
  localparam int COLS = WIDTH / P;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           ovf_q, ovf_d;
  logic           fd_q, fd_d;
  logic           event_s, push_s, pop_s, full_s, empty_s;
  logic           sof_s, eol_s, eof_s;
  logic [DDW-1:0] pix_s;
  logic [EW-1:0]  din_s, dout_s;

  // Word formation, tagging, counter advance and drop detection.
  always_comb begin
    pix_s   = '0;
    for (int l = 0; l < P; l++) begin
      if (in_valid_vec[l]) pix_s[l*PIX_W +: PIX_W] = in_pix_vec[l*PIX_W +: PIX_W];
      else                 pix_s[l*PIX_W +: PIX_W] = '0;
    end
    event_s = |in_valid_vec;
    sof_s   = (row_q == RW'(0)) && (col_q == CW'(0));
    eol_s   = (col_q == CW'(COLS - 1));
    eof_s   = eol_s && (row_q == RW'(HEIGHT - 1));
    din_s   = {sof_s, eol_s, eof_s, pix_s};
    pop_s   = !empty_s && m_ready && !clear;
    push_s  = event_s && !clear && (!full_s || pop_s);
    col_d   = col_q;
    row_d   = row_q;
    ovf_d   = ovf_q;
    fd_d    = pop_s && dout_s[DDW + EOF_OFS];
    if (clear) begin
      col_d = '0;
      row_d = '0;
      ovf_d = 1'b0;
    end else if (event_s) begin
      // Counters advance even for dropped words so geometry stays aligned.
      if (eol_s) begin
        col_d = '0;
        row_d = eof_s ? RW'(0) : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
      if (full_s && !pop_s) ovf_d = 1'b1;
      else                  ovf_d = ovf_q;
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ovf_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
      fd_q  <= fd_d;
    end
  end

  sync_fifo_fwft #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  assign m_valid    = !empty_s;
  assign m_data     = dout_s[DDW-1:0];
  assign m_sof      = dout_s[DDW + SOF_OFS];
  assign m_eol      = dout_s[DDW + EOL_OFS];
  assign m_eof      = dout_s[DDW + EOF_OFS];
  assign overflow   = ovf_q;
  assign frame_done = fd_q;

endmodule
